// File: rtl/fib_bcd_converter.sv
// -----------------------------------------------------------------------------
// fib_bcd_converter
//
// Purpose:
//   Converts one unsigned binary value (typically a Fibonacci result from
//   fibonacci_series) into packed BCD using a sequential shift-add-3
//   (double-dabble) engine, one bit per clock. Valid/ready handshakes on both
//   sides; a single conversion is in flight at a time.
//
// Parameters:
//   BIN_W   width of the binary input (default 20)
//   DIGITS  number of BCD output digits (default 7); 10^DIGITS must exceed
//           2^BIN_W - 1 or elaboration stops with an error.
//
// Ports:
//   clock      in   rising-edge clock for all state
//   reset      in   asynchronous active-low reset
//   in_valid   in   in_bin holds a value to convert
//   in_ready   out  converter is idle and can accept
//   in_bin     in   binary value, sampled on the accept edge only
//   out_valid  out  out_bcd holds a finished result
//   out_ready  in   consumer takes the result
//   out_bcd    out  packed BCD, digit 0 (units) in bits [3:0]; holds its value
//                   until the next conversion completes
//   busy       out  high while shifting or holding a result
//   out_blank  out  leading-zero flags per digit
//
// Build option:
//   FIB_BCD_BLANK_EN  when defined, out_blank[i] is 1 when digit i and every
//                     digit above it are zero (out_blank[0] is always 0).
//                     Otherwise out_blank is tied to zero.
// -----------------------------------------------------------------------------
module fib_bcd_converter #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 7
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  busy,
    output logic [DIGITS-1:0]     out_blank
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    // Reject digit counts too small to hold the largest input value.
    if ((64'd10 ** DIGITS) <= ((64'd1 << BIN_W) - 64'd1)) begin : g_digits_check
        $error("fib_bcd_converter: DIGITS too small for BIN_W");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [BIN_W-1:0]   r_sr;          // remaining binary bits, MSB first
    logic [BCD_W-1:0]   r_acc;         // BCD accumulator being built
    logic [BCD_W-1:0]   r_out_bcd;     // last finished result
    logic [CNT_W-1:0]   r_cnt;         // bits still to shift

    logic [BCD_W-1:0]   w_adj;         // accumulator after the add-3 step
    logic [BCD_W-1:0]   w_acc_shifted; // accumulator after this iteration
    logic               w_accept;
    logic               w_last;        // this SHIFT iteration is the final one
    logic               w_out_fire;

    assign w_accept   = (r_state == S_IDLE) && in_valid;
    assign w_last     = (r_state == S_SHIFT) && (r_cnt == CNT_W'(1));
    assign w_out_fire = (r_state == S_DONE) && out_ready;

    // Add 3 to every digit >= 5 independently so the following left shift
    // carries correctly into the next decimal digit.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
        assign w_adj[4*gi +: 4] = (r_acc[4*gi +: 4] >= 4'd5) ?
                                  (r_acc[4*gi +: 4] + 4'd3) : r_acc[4*gi +: 4];
    end

    assign w_acc_shifted = {w_adj[BCD_W-2:0], r_sr[BIN_W-1]};

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)   w_state_next = S_SHIFT;
            S_SHIFT: if (w_last)     w_state_next = S_DONE;
            S_DONE:  if (w_out_fire) w_state_next = S_IDLE;
            default:                 w_state_next = S_IDLE;
        endcase
    end

    // Conversion datapath
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sr      <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_out_bcd <= '0;
        end else begin
            if (w_accept) begin
                r_sr  <= in_bin;
                r_acc <= '0;
                r_cnt <= CNT_W'(BIN_W);
            end else if (r_state == S_SHIFT) begin
                r_sr  <= {r_sr[BIN_W-2:0], 1'b0};
                r_acc <= w_acc_shifted;
                r_cnt <= r_cnt - CNT_W'(1);
            end
            // Result register only changes when a conversion finishes.
            if (w_last) begin
                r_out_bcd <= w_acc_shifted;
            end
        end
    end

`ifdef FIB_BCD_BLANK_EN
    logic [DIGITS-1:0] w_blank;
    logic [DIGITS-1:0] r_blank;

    // Chain from the top digit down: a digit is blank only if it and all
    // higher digits are zero. The units digit is never blanked.
    assign w_blank[0] = 1'b0;
    for (genvar gi = 1; gi < DIGITS; gi++) begin : g_blank
        if (gi == DIGITS - 1) begin : g_top
            assign w_blank[gi] = (w_acc_shifted[4*gi +: 4] == 4'd0);
        end else begin : g_mid
            assign w_blank[gi] = (w_acc_shifted[4*gi +: 4] == 4'd0) && w_blank[gi+1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_blank <= '0;
        end else if (w_last) begin
            r_blank <= w_blank;
        end
    end

    assign out_blank = r_blank;
`else
    assign out_blank = '0;
`endif

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_bcd   = r_out_bcd;

endmodule

// File: tb/tb_fib_bcd_converter.sv
module tb_fib_bcd_converter;

    localparam int BIN_W  = 20;
    localparam int DIGITS = 7;

    logic                clock;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [BIN_W-1:0]    in_bin;
    logic                out_valid;
    logic                out_ready;
    logic [4*DIGITS-1:0] out_bcd;
    logic                busy;
    logic [DIGITS-1:0]   out_blank;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    fib_bcd_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .busy      (busy),
        .out_blank (out_blank)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Decimal digits by division; leading-zero flags from those digits.
    function automatic logic [4*DIGITS-1:0] to_bcd(input int unsigned v);
        logic [4*DIGITS-1:0] r;
        int unsigned p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [DIGITS-1:0] to_blank(input int unsigned v);
        logic [DIGITS-1:0] b;
        b = '0;
`ifdef FIB_BCD_BLANK_EN
        // digit i and above are all zero exactly when v < 10^i
        for (int i = 1; i < DIGITS; i++) begin
            int unsigned p;
            p = 1;
            for (int k = 0; k < i; k++) p = p * 10;
            b[i] = (v < p);
        end
`endif
        return b;
    endfunction

    // m_phase: 0 idle, 1 converting, 2 result waiting
    int                  m_phase = 0;
    int                  m_elapsed = 0;
    int unsigned         m_val = 0;
    logic [4*DIGITS-1:0] m_bcd = '0;
    logic [DIGITS-1:0]   m_blank = '0;
    int                  m_accepts = 0;
    int                  m_accept_cyc[$];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_phase   = 0;
            m_elapsed = 0;
            m_bcd     = '0;
            m_blank   = '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                       m_val     = in_bin;
                       m_elapsed = 0;
                       m_phase   = 1;
                       m_accepts++;
                       m_accept_cyc.push_back(cyc);
                   end
                1: begin
                       m_elapsed++;
                       if (m_elapsed == BIN_W) begin
                           m_phase = 2;
                           m_bcd   = to_bcd(m_val);
                           m_blank = to_blank(m_val);
                       end
                   end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    // Compare every cycle while out of reset
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            check("out_valid", 64'(out_valid), 64'(m_phase == 2));
            check("in_ready",  64'(in_ready),  64'(m_phase == 0));
            check("busy",      64'(busy),      64'(m_phase != 0));
            check("out_bcd",   64'(out_bcd),   64'(m_bcd));
            check("out_blank", 64'(out_blank), 64'(m_blank));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic conv(input logic [BIN_W-1:0] v, input logic [27:0] exp_bcd,
                        input logic [6:0] exp_blank, input int stall);
        int lat;
        @(negedge clock);
        in_bin    = v;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(negedge clock);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check("latency", 64'(lat), 64'(BIN_W));
        check("bcd_literal", 64'(out_bcd), 64'(exp_bcd));
`ifdef FIB_BCD_BLANK_EN
        check("blank_literal", 64'(out_blank), 64'(exp_blank));
`else
        check("blank_tied", 64'(out_blank), 64'(0 * exp_blank));
`endif
        if (stall > 0) begin
            in_bin   = 20'd123;
            in_valid = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(negedge clock);
                check("stall_bcd", 64'(out_bcd), 64'(exp_bcd));
                check("stall_in_ready", 64'(in_ready), 64'(0));
                check("stall_valid", 64'(out_valid), 64'(1));
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clock);
        check("idle_after", 64'(in_ready), 64'(1));
        check("hold_bcd", 64'(out_bcd), 64'(exp_bcd));
    endtask

    initial begin
        int acc_before;
        logic [27:0] b2b_exp [3];
        int          b2b_val [3];
        b2b_exp[0] = 28'h0000034; b2b_exp[1] = 28'h0000055; b2b_exp[2] = 28'h0000089;
        b2b_val[0] = 34;          b2b_val[1] = 55;          b2b_val[2] = 89;

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_bin = '0;
        repeat (2) @(negedge clock);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_bcd",   64'(out_bcd),   64'(0));
        check("rst_busy",      64'(busy),      64'(0));
        check("rst_out_blank", 64'(out_blank), 64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(1));
        reset = 1'b1;

        conv(20'd55,      28'h0000055, 7'b1111100, 0);
        conv(20'd0,       28'h0000000, 7'b1111110, 0);
        conv(20'd1048575, 28'h1048575, 7'b0000000, 0);
        acc_before = m_accepts;
        conv(20'd6765,    28'h0006765, 7'b1110000, 5);
        check("stall_ignored_accepts", 64'(m_accepts - acc_before), 64'(1));

        // Abort mid-conversion with an asynchronous reset
        @(negedge clock);
        in_bin = 20'd4181; in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (9) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'(0));
        check("abort_out_bcd",   64'(out_bcd),   64'(0));
        check("abort_busy",      64'(busy),      64'(0));
        check("abort_in_ready",  64'(in_ready),  64'(1));
        repeat (2) @(negedge clock);
        reset = 1'b1;
        conv(20'd89, 28'h0000089, 7'b1111100, 0);

        // Back-to-back with in_valid held and out_ready high
        m_accept_cyc.delete();
        @(negedge clock);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int guard;
            in_bin = BIN_W'(b2b_val[k]);
            guard = 0;
            while (m_phase == 0 && guard < 10) begin @(negedge clock); guard++; end
            check("b2b_accept_timeout", 64'(guard < 10), 64'(1));
            guard = 0;
            while (m_phase != 2 && guard < 40) begin @(negedge clock); guard++; end
            check("b2b_result", 64'(out_bcd), 64'(b2b_exp[k]));
            guard = 0;
            while (m_phase != 0 && guard < 10) begin @(negedge clock); guard++; end
            if (k == 2) in_valid = 1'b0;
        end
        check("b2b_accept_count", 64'(m_accept_cyc.size()), 64'(3));
        if (m_accept_cyc.size() == 3) begin
            check("b2b_gap1", 64'(m_accept_cyc[1] - m_accept_cyc[0]), 64'(BIN_W + 2));
            check("b2b_gap2", 64'(m_accept_cyc[2] - m_accept_cyc[1]), 64'(BIN_W + 2));
        end
        repeat (3) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fib_bcd_converter.md
# fib_bcd_converter

Downstream stage of `fibonacci_series`. It takes one 20-bit binary Fibonacci result and converts it to packed BCD digits for display or logging, using a sequential shift-add-3 (double-dabble) engine. Valid/ready handshakes are used on both sides. Only one conversion is in flight at a time.

## Interface
- `BIN_W`, 20, width of the binary input. It matches `fibonacci_number`.
- `DIGITS`, 7, number of BCD output digits. The elaboration check requires 10^DIGITS > 2^BIN_W - 1.
- `clock`  in  1  rising-edge clock for all state.
- `reset`  in  1  asynchronous, active-low reset. The block is in reset while `reset`=0.
- `in_valid`  in  1  `in_bin` holds a value to convert.
- `in_ready`  out  1  block can accept. Equals (state==IDLE).
- `in_bin`  in  BIN_W  unsigned binary value. It is sampled only on the accept edge.
- `out_valid`  out  1  `out_bcd` holds a finished result.
- `out_ready`  in  1  consumer takes the result.
- `out_bcd`  out  4*DIGITS  packed BCD. Digit 0 (units) is in bits [3:0].
- `busy`  out  1  high in SHIFT and DONE.
- `out_blank`  out  DIGITS  leading-zero flags. Active only with the macro (see Configuration).

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`:
    - load the shift register with `in_bin`;
    - clear the BCD accumulator;
    - load the bit counter with BIN_W;
    - go to SHIFT.
- **SHIFT**, one iteration per cycle:
  - Every accumulator digit ≥5 gets +3 (4-bit add; no carry between digits).
  - Then {accumulator, shift register} shifts left one bit and the counter decrements.
  - When the counter reaches 0, go to DONE.
- **DONE**
  - `out_valid`=1.
  - `out_bcd` holds the accumulator.
  - On `out_valid && out_ready`, go to IDLE.
- `in_valid` is ignored outside IDLE. No input is buffered.
- `out_bcd` keeps its last value after the handshake until the next conversion completes. It does not clear.
- Arithmetic:
  - The accumulator is 4*DIGITS bits.
  - The counter is $clog2(BIN_W+1) bits.
  - With a legal DIGITS, no digit ever exceeds 9.
- Reset at any time, including mid-SHIFT or in DONE:
  - the conversion is aborted;
  - state becomes IDLE;
  - no `out_valid` pulse is produced.

## Timing
- Reset values:
  - `out_valid`=0
  - `out_bcd`=0
  - `busy`=0
  - `out_blank`=0
  - `in_ready`=1 (decoded from IDLE)
- Latency: `out_valid` rises exactly BIN_W cycles after the accept edge (20 for the defaults).
- `busy` rises on the edge after accept and falls on the edge after the output handshake.
- `in_ready` is 0 from the cycle after accept until the cycle after the output handshake.
- Minimum accept-to-accept interval is BIN_W+2 cycles, reached with `out_ready` held 1.
- With `out_ready` held 0, `out_valid` and `out_bcd` stay stable indefinitely.
- `in_valid` asserted in the same cycle as the output handshake is not accepted. It is accepted on the following cycle, in IDLE.

## Configuration
- `FIB_BCD_BLANK_EN` defined:
  - `out_blank[i]`=1 when digit i and all digits above it are 0.
  - It is registered with `out_bcd` at the SHIFT→DONE edge.
  - `out_blank[0]` is always 0.
- Without the macro:
  - `out_blank` is tied to 0;
  - no blanking logic is compiled.

## Test plan
- Reset then `in_bin`=55 with `in_valid` for one cycle → after 20 cycles, `out_valid`=1 and `out_bcd`=28'h0000055.
- `in_bin`=0 → `out_bcd`=28'h0000000 after 20 cycles. With the macro, `out_blank`=7'b1111110.
- `in_bin`=1048575 → `out_bcd`=28'h1048575. With the macro, `out_blank`=7'b0000000.
- `in_bin`=6765 with `out_ready`=0 for 5 cycles after `out_valid` → `out_bcd`=28'h0006765 stable and `in_ready`=0 throughout. A second `in_valid` during those cycles is ignored.
- Accept `in_bin`=4181 and pull `reset` low 10 cycles after accept → immediately `out_valid`=0, `out_bcd`=0 and `busy`=0. After release, a new `in_bin`=89 yields 28'h0000089.
- Back-to-back inputs 34, 55, 89 with `in_valid` held and `out_ready`=1 → three results in order. Accept edges are 22 cycles apart.
